mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 21 ++
 rtl/mem_responder_mem_array.sv | 26 ++
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the mem_responder memory-bus slave.
// Bounds checking is enabled by defining MEM_BOUNDS_CHECK_EN.
package mem_responder_pkg;

    localparam int DEFAULT_WAIT_STATES = 2;
    localparam int DEFAULT_DEPTH       = 512;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int ADDR_W = addr_width(DEFAULT_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port DEPTH x 32 storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic          clock,
    input  logic          write_en,
    input  logic [AW-1:0] address,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[address] <= write_data;
        end
    end

    assign read_data = mem[address];

endmodule

// File: rtl/mem_responder.sv
// Memory responder with programmable wait states and one transaction per strobe.
// Define MEM_BOUNDS_CHECK_EN to flag (and neutralise) accesses with Address >= DEPTH.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
    parameter int DEPTH       = DEFAULT_DEPTH
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    output logic        Busy,
    output logic        Error
);

    localparam int AW = addr_width(DEPTH);

    state_t        state, state_next;
    logic [3:0]    count, count_next;
    logic          op_write;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [31:0]   read_word;
    logic          capture;
    logic          in_resp;
    logic          oob_q;
    logic          write_en;

    assign capture = (state == IDLE) && (Read || Write);
    assign in_resp = (state == RESP);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (Read || Write) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (count <= 4'd1) begin
                    state_next = RESP;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESP: state_next = HOLD;
            HOLD: begin
                if (!Read && !Write) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write wins when both strobes arrive together.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            op_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (capture) begin
            op_write <= Write;
            addr_q   <= Address[AW-1:0];
            data_q   <= DataIn;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            oob_q <= 1'b0;
        end else if (capture) begin
            oob_q <= (Address >= 32'(DEPTH));
        end
    end

    assign Error = in_resp && oob_q;
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^Address[31:AW];
    assign oob_q          = 1'b0;
    assign Error          = 1'b0;
`endif

    assign write_en = in_resp && op_write && !oob_q;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock      (Clock),
        .write_en   (write_en),
        .address    (addr_q),
        .write_data (data_q),
        .read_data  (read_word)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            DataOut <= '0;
        end else if (in_resp && !op_write) begin
            DataOut <= oob_q ? 32'h0 : read_word;
        end
    end

    assign Ready = in_resp;
    assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr, rd_f, wr_f;
    logic [31:0] addr, din, addr_f, din_f;
    logic [31:0] dout, dout_f;
    logic        rdy, busy, err, rdy_f, busy_f, err_f;

    int   tests = 0;
    int   fails = 0;
    int   rc, rp;
    logic es, bd, bi;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(WS), .DEPTH(512)) dut (
        .Clock(clk), .Reset_n(rst_n), .Read(rd), .Write(wr), .Address(addr),
        .DataIn(din), .DataOut(dout), .Ready(rdy), .Busy(busy), .Error(err)
    );

    mem_responder #(.WAIT_STATES(0), .DEPTH(512)) dut_fast (
        .Clock(clk), .Reset_n(rst_n), .Read(rd_f), .Write(wr_f), .Address(addr_f),
        .DataIn(din_f), .DataOut(dout_f), .Ready(rdy_f), .Busy(busy_f), .Error(err_f)
    );

    // Drives one strobe assertion held for 'hold' cycles, then waits (bounded) for IDLE.
    task automatic run_access(input bit fast, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d, input int hold,
                              output int ready_count, output int ready_pos,
                              output logic err_seen, output logic busy_dropped,
                              output logic back_idle);
        logic o_rdy, o_busy, o_err;
        ready_count  = 0;
        ready_pos    = -1;
        err_seen     = 1'b0;
        busy_dropped = 1'b0;
        back_idle    = 1'b0;
        @(negedge clk);
        if (fast) begin rd_f = r; wr_f = w; addr_f = a; din_f = d; end
        else      begin rd = r;   wr = w;   addr = a;   din = d;   end
        @(posedge clk);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (fast) begin addr_f = ~a; din_f = ~d; end
                else      begin addr = ~a;   din = ~d;   end
            end
            o_rdy  = fast ? rdy_f  : rdy;
            o_busy = fast ? busy_f : busy;
            o_err  = fast ? err_f  : err;
            if (o_rdy) begin
                ready_count++;
                ready_pos = k;
                if (o_err) err_seen = 1'b1;
            end
            if (!o_busy) busy_dropped = 1'b1;
        end
        if (fast) begin rd_f = 1'b0; wr_f = 1'b0; end
        else      begin rd = 1'b0;   wr = 1'b0;   end
        for (int k = 0; k < 6 && !back_idle; k++) begin
            @(negedge clk);
            if (!(fast ? busy_f : busy)) back_idle = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        rd = 0; wr = 0; addr = 0; din = 0;
        rd_f = 0; wr_f = 0; addr_f = 0; din_f = 0;
        #1 rst_n = 1'b0;
        #2;
        tests++; if (rdy !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b want 0", rdy); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        tests++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_error: got %b want 0", err); end
        tests++; if (dout !== 32'h0) begin fails++; $display("[TB] FAIL reset_dataout: got %h want 0", dout); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        run_access(0, 1'b0, 1'b1, 32'h10, 32'h0000_00A5, 5, rc, rp, es, bd, bi);
        tests++; if (rc !== 1 || rp !== WS) begin fails++; $display("[TB] FAIL write_ready: got count=%0d pos=%0d want count=1 pos=%0d", rc, rp, WS); end
        tests++; if (bd !== 1'b0 || bi !== 1'b1) begin fails++; $display("[TB] FAIL write_busy: got dropped=%b idle=%b want 0/1", bd, bi); end
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 5, rc, rp, es, bd, bi);
        tests++; if (rc !== 1 || rp !== WS) begin fails++; $display("[TB] FAIL read_ready: got count=%0d pos=%0d want count=1 pos=%0d", rc, rp, WS); end
        tests++; if (dout !== 32'h0000_00A5) begin fails++; $display("[TB] FAIL read_data: got %h want 000000a5", dout); end
    endtask

    task automatic test_precedence();
        run_access(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 5, rc, rp, es, bd, bi);
        tests++; if (dout !== 32'h0000_00A5) begin fails++; $display("[TB] FAIL write_keeps_dataout: got %h want 000000a5", dout); end
        run_access(0, 1'b1, 1'b0, 32'h20, 32'h0, 5, rc, rp, es, bd, bi);
        tests++; if (dout !== 32'h1234_5678) begin fails++; $display("[TB] FAIL precedence_data: got %h want 12345678", dout); end
    endtask

    task automatic test_hold();
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 10, rc, rp, es, bd, bi);
        tests++; if (rc !== 1) begin fails++; $display("[TB] FAIL hold_single_ready: got %0d pulses want 1", rc); end
        tests++; if (bd !== 1'b0) begin fails++; $display("[TB] FAIL hold_busy: busy dropped=%b want 0", bd); end
        tests++; if (bi !== 1'b1) begin fails++; $display("[TB] FAIL hold_release: idle=%b want 1", bi); end
    endtask

    task automatic test_reset_mid_write();
        run_access(0, 1'b0, 1'b1, 32'h30, 32'hCAFE_0001, 5, rc, rp, es, bd, bi);
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 5, rc, rp, es, bd, bi);
        @(negedge clk);
        wr = 1'b1; addr = 32'h30; din = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL midreset_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || rdy !== 1'b0 || err !== 1'b0) begin fails++; $display("[TB] FAIL midreset_flags: got busy=%b ready=%b error=%b want 0", busy, rdy, err); end
        tests++; if (dout !== 32'h0) begin fails++; $display("[TB] FAIL midreset_dataout: got %h want 0", dout); end
        wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_access(0, 1'b1, 1'b0, 32'h30, 32'h0, 5, rc, rp, es, bd, bi);
        tests++; if (dout !== 32'hCAFE_0001) begin fails++; $display("[TB] FAIL midreset_old_value: got %h want cafe0001", dout); end
    endtask

    task automatic test_bounds();
        logic [31:0] oob_addr;
        logic [31:0] wrap_word;
        oob_addr  = 32'h200;
        wrap_word = oob_addr & ((32'd1 << ADDR_W) - 32'd1);
        run_access(0, 1'b0, 1'b1, wrap_word, 32'h0BAD_0000, 5, rc, rp, es, bd, bi);
        run_access(0, 1'b1, 1'b0, oob_addr, 32'h0, 5, rc, rp, es, bd, bi);
`ifdef MEM_BOUNDS_CHECK_EN
        tests++; if (es !== 1'b1 || rc !== 1) begin fails++; $display("[TB] FAIL bounds_error: got error=%b pulses=%0d want 1/1", es, rc); end
        tests++; if (dout !== 32'h0) begin fails++; $display("[TB] FAIL bounds_data: got %h want 0", dout); end
`else
        tests++; if (es !== 1'b0 || rc !== 1) begin fails++; $display("[TB] FAIL wrap_error: got error=%b pulses=%0d want 0/1", es, rc); end
        tests++; if (dout !== 32'h0BAD_0000) begin fails++; $display("[TB] FAIL wrap_data: got %h want 0bad0000", dout); end
`endif
    endtask

    task automatic test_zero_wait();
        run_access(1, 1'b0, 1'b1, 32'h7, 32'h0000_0077, 5, rc, rp, es, bd, bi);
        tests++; if (rc !== 1 || rp !== 0) begin fails++; $display("[TB] FAIL zw_write_ready: got count=%0d pos=%0d want 1/0", rc, rp); end
        run_access(1, 1'b1, 1'b0, 32'h7, 32'h0, 5, rc, rp, es, bd, bi);
        tests++; if (rc !== 1 || rp !== 0) begin fails++; $display("[TB] FAIL zw_read_ready: got count=%0d pos=%0d want 1/0", rc, rp); end
        tests++; if (dout_f !== 32'h0000_0077) begin fails++; $display("[TB] FAIL zw_read_data: got %h want 00000077", dout_f); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_precedence();
        test_hold();
        test_reset_mid_write();
        test_bounds();
        test_zero_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
